node_dispatch_fifo: RTL and testbench
=====================================

Name: node_dispatch_fifo

Overview:
- Parametrised successor to the node instruction sender: routes each incoming instruction to the self, right or left channel, or to all three (broadcast).
- Each channel has its own FIFO, so one stalled neighbour does not block traffic to the others.
- Uses a valid/ready handshake on every interface instead of one-cycle check flags, and drives defined values rather than Z.
- Sits between the node's instruction source and the self CPU and neighbour links.

Parameters:
WIDTH, 32, instruction width in bits
DEPTH, 4, entries per channel FIFO; power of two, at least 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source has an instruction
in_ready  output  1  dispatcher accepts this cycle
in_dir  input  2  destination: 01 self, 00 right, 10 left, 11 broadcast
in_instr  input  WIDTH  instruction payload
self_valid, right_valid, left_valid  output  1 each  channel head entry valid
self_ready, right_ready, left_ready  input  1 each  consumer takes the head entry
self_instr, right_instr, left_instr  output  WIDTH each  channel head payload
self_count, right_count, left_count  output  CNT_W each  channel occupancy
bcast_count  output  16  number of accepted broadcasts; saturates at 16'hFFFF

Behaviour:
- Reset:
  - rst_n low clears all FIFOs immediately (asynchronous assert).
  - During reset: all *_valid = 0, all *_instr = 0, all *_count = 0, bcast_count = 0, in_ready = 0.
  - Deassertion is synchronised by the user. The first accept is possible on the first rising edge with rst_n high.
- Output payload: *_instr equals the head entry when *_valid = 1, and is 0 otherwise. Z is never driven.
- in_ready (combinational from registered counts and in_dir only):
  - Unicast: in_ready = 1 when the target FIFO count < DEPTH.
  - Broadcast: in_ready = 1 only when all three counts < DEPTH.
  - Full is judged on the current count. A pop in the same cycle does not free a slot for a push in that cycle.
- Accept: a transfer happens when in_valid & in_ready at the rising edge.
  - Unicast: push into the target FIFO.
  - Broadcast: push the same payload into all three FIFOs in the same cycle and increment bcast_count.
  - in_valid with in_ready = 0: no state change. The source must hold in_instr and in_dir stable until accepted.
- Latency: an instruction accepted at edge N is visible as valid at the head of an empty channel after edge N (i.e. in cycle N+1). There is no combinational input-to-output bypass.
- Pop: consumer transfer when *_valid & *_ready at the rising edge. The next entry, if any, appears in the following cycle.
- Simultaneous push and pop on a non-full, non-empty channel: count unchanged, order preserved.
- Push into an empty channel while the consumer holds ready: the entry still shows valid for at least one cycle.
- Ordering: strict FIFO per channel. There is no ordering guarantee between channels.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is kept separately, range 0..DEPTH.
- Channel state, per FIFO, derived from the count:
  - EMPTY: count = 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count = DEPTH.
  - Transitions by ±1 per cycle only.
- *_ready asserted while *_valid = 0 is ignored and never underflows the count.
- Reset mid-operation: all in-flight entries are discarded and no partial broadcast survives.

Decomposition:
- Shared package: direction encodings DIR_RIGHT = 2'b00, DIR_SELF = 2'b01, DIR_LEFT = 2'b10, DIR_BCAST = 2'b11, plus the default WIDTH. The package is reused by the neighbour link receivers.
- One sub-module, chan_fifo (WIDTH, DEPTH): push/pop, count, zero-masked head output. It is instantiated three times.
- Top level holds only direction decode, in_ready logic and the broadcast counter.

Test Plan:
1. Reset, then unicast 32'hA5A5_0001 with in_dir = 01 -> self_valid = 1 and self_instr = 32'hA5A5_0001 one cycle after accept; left and right outputs stay 0 with valid = 0.
2. Hold right_ready = 0 and send 5 instructions with in_dir = 00 (DEPTH = 4) -> 4 accepted, right_count = 4, in_ready = 0 on the 5th. Then raise right_ready for one cycle -> the 5th is accepted the cycle after the pop. Drain order is preserved.
3. Right channel full, then send in_dir = 10 -> accepted immediately (no head-of-line blocking); left_count = 1.
4. Broadcast 32'hDEAD_BEEF with all channels empty -> all three valid with the same payload the next cycle; bcast_count = 1. Repeat with left full -> in_ready = 0 and no channel changes.
5. Channel holding 2 entries, push and pop the same cycle -> count stays 2. Run a wrap-around sequence of 10 pushes/pops -> data matches the scoreboard.
6. Drop rst_n asynchronously, mid-cycle, with 3 entries queued -> all valid/count/instr outputs go to 0 before the next edge. After release, new traffic is unaffected.

Source files
------------

// File: rtl/node_dispatch_fifo_pkg.sv
// Shared definitions for the node dispatcher and link receivers.
// Direction codes, default width and channel occupancy states.
package node_dispatch_fifo_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_SELF  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_BCAST = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    CH_EMPTY,
    CH_PARTIAL,
    CH_FULL
  } chan_state_e;

  function automatic chan_state_e chan_state(
    input int cnt,
    input int depth
  );
    if (cnt == 0)
      return CH_EMPTY;
    else if (cnt >= depth)
      return CH_FULL;
    else
      return CH_PARTIAL;
  endfunction

endpackage

// File: rtl/node_dispatch_fifo_chan_fifo.sv
// One dispatcher channel: circular buffer with separate count.
// Head payload is forced to zero whenever the channel is empty.
module chan_fifo
  import node_dispatch_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  chan_state_e w_state;
  logic        w_push;
  logic        w_pop;

  assign w_state = chan_state(int'(r_count), DEPTH);
  assign w_push  = i_push & (w_state != CH_FULL);
  assign w_pop   = i_ready & (w_state != CH_EMPTY);

  assign o_valid = (w_state != CH_EMPTY);
  assign o_full  = (w_state == CH_FULL);
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  // Pointers wrap modulo DEPTH; count moves by at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage write on accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/node_dispatch_fifo.sv
// Routes instructions to self/right/left channels or all three.
// Each channel buffers independently to avoid head-of-line blocking.
module node_dispatch_fifo
  import node_dispatch_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_dir,
  input  logic [WIDTH-1:0] in_instr,
  output logic             self_valid,
  output logic             right_valid,
  output logic             left_valid,
  input  logic             self_ready,
  input  logic             right_ready,
  input  logic             left_ready,
  output logic [WIDTH-1:0] self_instr,
  output logic [WIDTH-1:0] right_instr,
  output logic [WIDTH-1:0] left_instr,
  output logic [CNT_W-1:0] self_count,
  output logic [CNT_W-1:0] right_count,
  output logic [CNT_W-1:0] left_count,
  output logic [15:0]      bcast_count
);

  logic        w_full_s;
  logic        w_full_r;
  logic        w_full_l;
  logic        w_sel_s;
  logic        w_sel_r;
  logic        w_sel_l;
  logic        w_bc;
  logic        w_rdy;
  logic        w_acc;
  logic [15:0] r_bcast;

  // Decode destination and judge space on current counts only.
  always_comb begin
    w_sel_s = 1'b0;
    w_sel_r = 1'b0;
    w_sel_l = 1'b0;
    w_bc    = 1'b0;
    w_rdy   = 1'b0;
    unique case (1'b1)
      (in_dir == DIR_SELF): begin
        w_sel_s = 1'b1;
        w_rdy   = ~w_full_s;
      end
      (in_dir == DIR_RIGHT): begin
        w_sel_r = 1'b1;
        w_rdy   = ~w_full_r;
      end
      (in_dir == DIR_LEFT): begin
        w_sel_l = 1'b1;
        w_rdy   = ~w_full_l;
      end
      default: begin
        w_sel_s = 1'b1;
        w_sel_r = 1'b1;
        w_sel_l = 1'b1;
        w_bc    = 1'b1;
        w_rdy   = ~(w_full_s | w_full_r | w_full_l);
      end
    endcase
  end

  assign in_ready    = rst_n & w_rdy;
  assign w_acc       = in_valid & in_ready;
  assign bcast_count = r_bcast;

  // Saturating count of accepted broadcasts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bcast <= '0;
    else if (w_acc && w_bc && r_bcast != 16'hFFFF)
      r_bcast <= r_bcast + 16'd1;
  end

  chan_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_self (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc & w_sel_s),
    .i_data  (in_instr),
    .i_ready (self_ready),
    .o_valid (self_valid),
    .o_data  (self_instr),
    .o_count (self_count),
    .o_full  (w_full_s)
  );

  chan_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_right (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc & w_sel_r),
    .i_data  (in_instr),
    .i_ready (right_ready),
    .o_valid (right_valid),
    .o_data  (right_instr),
    .o_count (right_count),
    .o_full  (w_full_r)
  );

  chan_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_left (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc & w_sel_l),
    .i_data  (in_instr),
    .i_ready (left_ready),
    .o_valid (left_valid),
    .o_data  (left_instr),
    .o_count (left_count),
    .o_full  (w_full_l)
  );

endmodule

// File: tb/tb_node_dispatch_fifo.sv
// Directed and random checks of node_dispatch_fifo against
// per-channel queue model.
module tb_node_dispatch_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_dir = 2'b00;
  logic [W-1:0]  in_instr = '0;
  logic          self_valid, right_valid, left_valid;
  logic          self_ready = 1'b0;
  logic          right_ready = 1'b0;
  logic          left_ready = 1'b0;
  logic [W-1:0]  self_instr, right_instr, left_instr;
  logic [CW-1:0] self_count, right_count, left_count;
  logic [15:0]   bcast_count;

  always #5 clk = ~clk;

  node_dispatch_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dir      (in_dir),
    .in_instr    (in_instr),
    .self_valid  (self_valid),
    .right_valid (right_valid),
    .left_valid  (left_valid),
    .self_ready  (self_ready),
    .right_ready (right_ready),
    .left_ready  (left_ready),
    .self_instr  (self_instr),
    .right_instr (right_instr),
    .left_instr  (left_instr),
    .self_count  (self_count),
    .right_count (right_count),
    .left_count  (left_count),
    .bcast_count (bcast_count)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [W-1:0] qs[$];
  logic [W-1:0] qr[$];
  logic [W-1:0] ql[$];
  logic [15:0]  bcnt = '0;
  bit           m_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (!rst_n) return 1'b0;
    case (in_dir)
      2'b01: return qs.size() < D;
      2'b00: return qr.size() < D;
      2'b10: return ql.size() < D;
      default: return qs.size() < D && qr.size() < D
                      && ql.size() < D;
    endcase
  endfunction

  function automatic logic [31:0] head(input logic [W-1:0] q[$]);
    return (q.size() != 0) ? q[0] : 32'd0;
  endfunction

  task automatic chk_outs(input string t);
    chk({t, ".s_valid"}, 32'(self_valid), 32'(qs.size() != 0));
    chk({t, ".s_instr"}, self_instr, head(qs));
    chk({t, ".s_count"}, 32'(self_count), qs.size());
    chk({t, ".r_valid"}, 32'(right_valid), 32'(qr.size() != 0));
    chk({t, ".r_instr"}, right_instr, head(qr));
    chk({t, ".r_count"}, 32'(right_count), qr.size());
    chk({t, ".l_valid"}, 32'(left_valid), 32'(ql.size() != 0));
    chk({t, ".l_instr"}, left_instr, head(ql));
    chk({t, ".l_count"}, 32'(left_count), ql.size());
    chk({t, ".bcast"}, 32'(bcast_count), 32'(bcnt));
  endtask

  // One clock: drive at negedge, check ready, model the edge, check.
  task automatic cyc(input string t, input bit v, input logic [1:0] d,
                     input logic [W-1:0] x,
                     input bit sr, input bit rr, input bit lr);
    in_valid    = v;
    in_dir      = d;
    in_instr    = x;
    self_ready  = sr;
    right_ready = rr;
    left_ready  = lr;
    #1;
    chk({t, ".in_ready"}, 32'(in_ready), 32'(exp_ready()));
    m_acc = v && exp_ready();
    @(posedge clk);
    if (sr && qs.size() != 0) void'(qs.pop_front());
    if (rr && qr.size() != 0) void'(qr.pop_front());
    if (lr && ql.size() != 0) void'(ql.pop_front());
    if (m_acc) begin
      case (d)
        2'b01: qs.push_back(x);
        2'b00: qr.push_back(x);
        2'b10: ql.push_back(x);
        default: begin
          qs.push_back(x);
          qr.push_back(x);
          ql.push_back(x);
          if (bcnt != 16'hFFFF) bcnt = bcnt + 16'd1;
        end
      endcase
    end
    @(negedge clk);
    chk_outs(t);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      cyc("drain", 1'b0, 2'b00, '0, 1'b1, 1'b1, 1'b1);
  endtask

  bit           pend;
  bit           rv;
  logic [1:0]   pd;
  logic [W-1:0] px;

  initial begin
    // Reset state, with a request pending.
    in_valid = 1'b1;
    in_dir   = 2'b01;
    in_instr = 32'h1234_5678;
    @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: unicast to self.
    cyc("t1", 1'b1, 2'b01, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    chk("t1.s_instr_k", self_instr, 32'hA5A5_0001);
    chk("t1.l_valid_k", 32'(left_valid), 32'd0);
    chk("t1.r_instr_k", right_instr, 32'd0);

    // 2: fill right, fifth stalls until one pop.
    for (int i = 0; i < 5; i++)
      cyc("t2.fill", 1'b1, 2'b00, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
    chk("t2.r_count_k", 32'(right_count), 32'd4);
    chk("t2.in_ready_k", 32'(in_ready), 32'd0);
    cyc("t2.pop", 1'b1, 2'b00, 32'h1004, 1'b0, 1'b1, 1'b0);
    chk("t2.r_head_k", right_instr, 32'h1001);
    cyc("t2.acc5", 1'b1, 2'b00, 32'h1004, 1'b0, 1'b0, 1'b0);
    chk("t2.r_count5_k", 32'(right_count), 32'd4);

    // 3: left not blocked by full right.
    cyc("t3", 1'b1, 2'b10, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
    chk("t3.l_count_k", 32'(left_count), 32'd1);
    drain(6);

    // 4: broadcast to empty channels, then blocked by full left.
    cyc("t4", 1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("t4.s_k", self_instr, 32'hDEAD_BEEF);
    chk("t4.r_k", right_instr, 32'hDEAD_BEEF);
    chk("t4.l_k", left_instr, 32'hDEAD_BEEF);
    chk("t4.bc_k", 32'(bcast_count), 32'd1);
    for (int i = 0; i < 3; i++)
      cyc("t4.fill", 1'b1, 2'b10, 32'hC000 + i, 1'b0, 1'b0, 1'b0);
    cyc("t4.blk", 1'b1, 2'b11, 32'hFEED_0001, 1'b0, 1'b0, 1'b0);
    chk("t4.blk_rdy_k", 32'(in_ready), 32'd0);
    chk("t4.blk_s_k", 32'(self_count), 32'd1);
    chk("t4.blk_bc_k", 32'(bcast_count), 32'd1);
    for (int i = 0; i < 2; i++)
      cyc("t4.rel", 1'b1, 2'b11, 32'hFEED_0001, 1'b1, 1'b1, 1'b1);
    drain(6);

    // 5: simultaneous push/pop and pointer wrap.
    cyc("t5.a", 1'b1, 2'b01, 32'h5100, 1'b0, 1'b0, 1'b0);
    cyc("t5.b", 1'b1, 2'b01, 32'h5101, 1'b0, 1'b0, 1'b0);
    cyc("t5.pp", 1'b1, 2'b01, 32'h5102, 1'b1, 1'b0, 1'b0);
    chk("t5.s_count_k", 32'(self_count), 32'd2);
    chk("t5.s_head_k", self_instr, 32'h5101);
    for (int i = 0; i < 10; i++)
      cyc("t5.wrap", 1'b1, 2'b01, 32'h5200 + i, 1'b1, 1'b0, 1'b0);

    // 6: asynchronous reset mid-cycle with 3 queued.
    cyc("t6.q", 1'b1, 2'b01, 32'h6000, 1'b0, 1'b0, 1'b0);
    in_valid   = 1'b0;
    self_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    qs.delete();
    qr.delete();
    ql.delete();
    bcnt = '0;
    chk("t6.in_ready", 32'(in_ready), 32'd0);
    chk_outs("t6.rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t6.post", 1'b1, 2'b01, 32'h6100, 1'b0, 1'b0, 1'b0);
    chk("t6.s_count_k", 32'(self_count), 32'd1);
    drain(2);

    // Random traffic; unaccepted requests are held stable.
    pend = 1'b0;
    rv   = 1'b0;
    pd   = 2'b00;
    px   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 3) != 0);
        pd = 2'($urandom_range(0, 3));
        px = $urandom;
      end
      cyc("rnd", rv, pd, px,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) != 0);
      pend = rv && !m_acc;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
